seg_scan_ctrl: RTL

Time-multiplexed driver for the calculator's 4-digit seven-segment display. It generates the 2-bit digit select that steers the upstream 4:1 segment mux, and it takes that mux's shared 7-bit segment bus back in. It then drives the per-digit active-low anodes and a registered, blanked segment bus to the pins. A dead-time blank is inserted at the start of every digit slot to prevent ghosting.

---
 rtl/seg_scan_ctrl.sv | 94 +++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// ============================================================================
// Module   : seg_scan_ctrl
// Brief    : 4-digit seven-segment scan driver with per-slot dead-time blank.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_ctrl #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] digit_en,
  input  logic [0:6] seg_in,
  output logic [1:0] sel,
  output logic [3:0] an,
  output logic [0:6] seg,
  output logic       slot_start
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] C_LAST      = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] C_BLANK_END = CW'(BLANK_CYCLES - 1);

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [1:0]      w_sel_nxt;
  logic [3:0]      w_an_nxt;
  logic [0:6]      w_seg_nxt;
  logic            w_slot_nxt;
  logic            w_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      sel        <= 2'd0;
      r_state    <= BLANK;
      an         <= 4'b1111;
      seg        <= 7'b1111111;
      slot_start <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      sel        <= w_sel_nxt;
      r_state    <= w_state_nxt;
      an         <= w_an_nxt;
      seg        <= w_seg_nxt;
      slot_start <= w_slot_nxt;
    end
  end

  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_sel_nxt   = sel;
    w_state_nxt = BLANK;
    w_slot_nxt  = 1'b0;
    w_an_nxt    = 4'b1111;
    w_seg_nxt   = 7'b1111111;
    w_wrap      = (r_cnt == C_LAST);

    // With en low the counters freeze and the state is forced dark.
    if (en) begin
      w_state_nxt = r_state;
      if (w_wrap) begin
        w_cnt_nxt   = '0;
        w_sel_nxt   = sel + 2'd1;
        w_slot_nxt  = 1'b1;
        w_state_nxt = BLANK;
      end else begin
        w_cnt_nxt = r_cnt + CW'(1);
        if (r_state == BLANK && r_cnt == C_BLANK_END)
          w_state_nxt = SHOW;
      end
    end

    // Outputs are computed from the upcoming state so they stay registered.
    if (w_state_nxt == SHOW) begin
      w_seg_nxt = seg_in;
      if (digit_en[w_sel_nxt])
        w_an_nxt = ~(4'b0001 << w_sel_nxt);
    end
  end

endmodule

`default_nettype wire
